// File: rtl/moore_seq_detector_pkg.sv
// Shared definitions for the serial pattern detectors: default pattern,
// state-width helper and the overlap-mode encoding.
package moore_seq_detector_pkg;

  localparam int         DEF_PAT_LEN = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;

  typedef enum logic {
    MODE_RESTART = 1'b0,
    MODE_OVERLAP = 1'b1
  } overlap_mode_e;

  // State holds a matched-prefix length 0..pat_len inclusive.
  function automatic int state_width(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector: KMP-style prefix tracking, overlap/restart
// mode, input qualifier, synchronous clear and saturating match counter.
module moore_seq_detector
  import moore_seq_detector_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int                 OVERLAP = 1,
  parameter int                 CNT_W   = 8,
  localparam int                SW      = state_width(PAT_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             ip,
  output logic             op,
  output logic [SW-1:0]    state_o,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               TBL_N   = 2 ** (SW + 1);
  localparam logic [SW-1:0]    FULL    = SW'(PAT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Bit i of the pattern in arrival order (i = 0 is received first).
  function automatic logic pat_bit(input int i);
    logic [PAT_LEN-1:0] sh;
    sh = PATTERN >> (PAT_LEN - 1 - i);
    return sh[0];
  endfunction

  // Longest pattern prefix that is a suffix of (matched prefix of length s) + b.
  function automatic logic [SW-1:0] next_state(input int s, input logic b);
    int   se;
    int   len;
    int   best;
    int   pos;
    logic ok;
    logic cb;
    if (s > PAT_LEN) return '0;
    se   = (s == PAT_LEN && OVERLAP == int'(MODE_RESTART)) ? 0 : s;
    len  = se + 1;
    best = 0;
    for (int k = 1; k <= PAT_LEN; k++) begin
      if (k <= len) begin
        ok = 1'b1;
        for (int j = 0; j < PAT_LEN; j++) begin
          if (j < k) begin
            pos = len - k + j;
            cb  = (pos < se) ? pat_bit(pos) : b;
            if (cb != pat_bit(j)) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return SW'(best);
  endfunction

  logic [SW-1:0]    w_tbl [TBL_N];
  logic [SW-1:0]    w_next;
  logic             w_hit;
  logic [SW-1:0]    r_state;
  logic             r_op;
  logic [CNT_W-1:0] r_cnt;

  // Transition table indexed by {state, ip}; encodings above PAT_LEN map to 0.
  for (genvar g = 0; g < TBL_N; g++) begin : g_tbl
    assign w_tbl[g] = next_state(g / 2, 1'(g % 2));
  end

  assign w_next = w_tbl[{r_state, ip}];
  assign w_hit  = (w_next == FULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= '0;
      r_op    <= 1'b0;
    end else if (clear) begin
      r_state <= '0;
      r_op    <= 1'b0;
    end else if (en) begin
      r_state <= w_next;
      r_op    <= w_hit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en && w_hit && r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign op        = r_op;
  assign state_o   = r_state;
  assign match_cnt = r_cnt;

endmodule
